// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction-memory responder and its RAM.
//   NOP_INSTR         - word returned in place of an instruction on a bad fetch
//   ERR_*             - rsp_err status codes
//   rsp_t             - response bundle {instr, addr, err} at the default 32-bit widths
//   rsp_state_e       - response-register occupancy
//   classify_fetch()  - maps address checks onto an error code, misalignment first
package imem_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [1:0]  ERR_OK       = 2'd0;
  localparam logic [1:0]  ERR_MISALIGN = 2'd1;
  localparam logic [1:0]  ERR_RANGE    = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  err;
  } rsp_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_state_e;

  // Misalignment outranks range, so a misaligned out-of-range address reports 1.
  function automatic logic [1:0] classify_fetch(input logic misaligned,
                                                input logic out_of_range);
    if (misaligned)        return ERR_MISALIGN;
    else if (out_of_range) return ERR_RANGE;
    else                   return ERR_OK;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x DATA_W synchronous RAM, one write port, one read port.
//   clk    - clock
//   we     - write strobe; wdata lands at waddr on the edge
//   waddr  - write word index
//   wdata  - write data
//   re     - read enable; rdata updates on the edge only when set
//   raddr  - read word index
//   rdata  - registered read data, held between reads
// No reset: contents and rdata survive the responder's reset.
module imem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holding between reads is what keeps a stalled response stable.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: PC-side instruction fetch responder with one-deep
// valid/ready response register and a program-load write port.
//   clk, rst_n             - clock, synchronous active-low reset
//   req_valid/req_ready    - fetch request handshake
//   req_addr               - byte address of the instruction
//   flush                  - drop the held response (redirect)
//   rsp_valid/rsp_ready    - response handshake
//   rsp_instr/addr/err     - response payload (NOP on error)
//   load_we/addr/data      - program preload write, blocks fetches that cycle
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_err,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data
);

  rsp_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        err_q;
  logic              rd_ok_q;   // response carries RAM data (not NOP / not reset)
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-3:0] word_idx;
  logic              in_range;
  logic [1:0]        req_err;
  logic              accept;
  logic              rd_en;
  logic              wr_en;
  rsp_t              rsp_view;

  assign word_idx  = req_addr[ADDR_W-1:2];
  assign in_range  = word_idx < (ADDR_W-2)'(DEPTH_WORDS);
  assign req_err   = classify_fetch(req_addr[1:0] != 2'b00, !in_range);

  // A free slot exists if empty, or the held response leaves this cycle.
  assign req_ready = !load_we && ((state == S_EMPTY) || rsp_ready || flush);
  assign accept    = req_valid && req_ready;

  // Reset wins over any same-cycle fetch or load.
  assign rd_en     = rst_n && accept && (req_err == ERR_OK);
  assign wr_en     = rst_n && load_we;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (wr_en),
    .waddr(load_addr),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(word_idx[IDX_W-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      addr_q  <= '0;
      err_q   <= ERR_OK;
      rd_ok_q <= 1'b0;
    end else if (accept) begin
      state   <= S_FULL;
      addr_q  <= req_addr;
      err_q   <= req_err;
      rd_ok_q <= (req_err == ERR_OK);
    end else if (rsp_ready || flush) begin
      // Drain or flush: only occupancy changes, payload keeps its last value.
      state   <= S_EMPTY;
    end
  end

  // Instruction comes straight off the RAM output register, which was loaded on
  // the same edge as the response register, so no req_* to rsp_* comb path.
  always_comb begin
    rsp_view       = '0;
    rsp_view.instr = 32'(rd_ok_q ? rdata : DATA_W'(NOP_INSTR));
    rsp_view.addr  = 32'(addr_q);
    rsp_view.err   = err_q;
  end

  assign rsp_valid = (state == S_FULL);
  assign rsp_instr = DATA_W'(rsp_view.instr);
  assign rsp_addr  = ADDR_W'(rsp_view.addr);
  assign rsp_err   = rsp_view.err;

endmodule
